i2c_slave: RTL and testbench
============================

# i2c_slave

Single-clock I2C target that pairs with `i2c_master` on the same two-wire bus. It oversamples SCL/SDA, detects START/STOP, and matches its 7-bit address. It ACKs the address and register-pointer bytes, then either accepts two write data bytes (MSB byte first) or returns two read data bytes. It exposes a simple 16-bit register-file port toward the local design.

## Interface
- `SLAVE_ADDRESS`, default 7'h42: bus address this target answers to.
- `SYNC_STAGES`, default 2: synchronizer depth on `scl_i`/`sda_i`, minimum 2.
- `clk  in  1`: the only clock. Must be at least 20× the SCL rate.
- `rst  in  1`: reset, synchronous, active-high.
- `scl_i  in  1`: bus SCL, asynchronous.
- `sda_i  in  1`: bus SDA, asynchronous.
- `sda_oe  out  1`: 1 pulls SDA low; 0 releases it (open-drain).
- `reg_addr  out  8`: register pointer received in the second byte.
- `reg_wdata  out  16`: write data, `{byte1, byte2}`.
- `reg_we  out  1`: one-clk write strobe.
- `reg_re  out  1`: one-clk read request.
- `reg_rdata  in  16`: read data. Must be valid on the clk after `reg_re`.
- `busy  out  1`: high from START detect until STOP or abort.

## Operation
- Line conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are evaluated on synchronized signals.
- Bit handling:
  - Data bits are MSB first.
  - SDA is sampled on each SCL rise.
  - `sda_oe` changes only on an SCL fall, except when released by STOP or abort.
- Byte 1 is `{addr[6:0], rw}`. The R/W convention is rw=1 write (controller→target) and rw=0 read.
- FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR_B1, WR_B1_ACK, WR_B2, WR_B2_ACK, RD_B1, RD_B1_ACK, RD_B2, RD_B2_ACK, IGNORE.
- Transitions:
  - IDLE → ADDR on START.
  - ADDR → ADDR_ACK after 8 bits, if the address matches `SLAVE_ADDRESS`. On a mismatch → IGNORE, and `sda_oe` stays 0.
  - ADDR_ACK → REG. REG → REG_ACK after 8 bits; `reg_addr` is updated at the 8th bit.
  - REG_ACK → WR_B1 if rw=1, else RD_B1.
  - Write path: WR_B1 → WR_B1_ACK → WR_B2 → WR_B2_ACK → IGNORE.
  - Read path: RD_B1 → RD_B1_ACK → RD_B2 → RD_B2_ACK → IGNORE.
- ACK: in each *_ACK state of the address, register and write paths, `sda_oe`=1 for the full 9th SCL period, from SCL fall to SCL fall.
- Write completion: at the 8th-bit rise of WR_B2, `reg_wdata` ← `{byte1, byte2}` and `reg_we` pulses for 1 clk.
- Read sequence:
  - On the SCL fall that ends REG_ACK, `reg_re` pulses.
  - On the next clk, `reg_rdata` is captured into the shift register and `sda_oe` = ~bit15.
  - During RD_*_ACK the target releases SDA. The controller ACK/NACK is sampled and ignored.
- IGNORE holds `sda_oe`=0 until the next START or STOP.
- START in any state (repeated START) → ADDR, bit counter cleared, `sda_oe`=0, no strobe.
- STOP in any state → IDLE, `busy`=0, `sda_oe`=0. A partial write is discarded and `reg_we` does not pulse.

## Timing
- Reset values:
  - `sda_oe`=0, `reg_we`=0, `reg_re`=0, `busy`=0.
  - `reg_addr`=8'h00, `reg_wdata`=16'h0000.
  - FSM state = IDLE; bit counter = 0; synchronizer flops = 1.
- A reset mid-transfer releases SDA on the same clk edge. The target then waits for a fresh START.
- Edge-detect latency: pin change → internal edge/START/STOP flag = `SYNC_STAGES`+1 clks.
- `sda_oe` update = 1 clk after the internal SCL-fall flag. The first read bit is 2 clks after it, because of the `reg_re` cycle.
- `reg_we` is asserted 1 clk after the internal SCL-rise flag of the 16th data bit. `reg_addr`/`reg_wdata` hold until the next write.
- `busy` rises 1 clk after START detect and falls 1 clk after STOP detect.
- Bit counter is 4 bits, 0..8, and is cleared at every byte boundary.

## Structure
- Shared package `i2c_pkg`:
  - FSM state encodings.
  - `I2C_RW_WRITE`=1'b1.
  - ACK/NACK level constants.
- Sub-module `i2c_sync_edge`: the SYNC_STAGES synchronizers plus the `scl_rise`/`scl_fall`/`start`/`stop` one-clk flags.
- The FSM, shift register and register port stay in `i2c_slave`.

## Test plan
- Write `0x42`/rw=1, reg `0x10`, data `0xBEEF`, STOP → three ACKs seen, `reg_we` pulses once, `reg_addr`=0x10, `reg_wdata`=0xBEEF.
- Read `0x42`/rw=0, reg `0x05`, `reg_rdata`=0xA55A → `reg_re` pulses once, SDA carries `0xA5` then `0x5A`, and SDA is released in both ack slots.
- Address `0x43` → no ACK, `reg_we`/`reg_re` never assert, `busy` drops at STOP.
- STOP after `byte1`=0x12 of a write → no `reg_we`, `reg_wdata` unchanged, FSM in IDLE.
- Repeated START in mid-REG byte, then a full write of `0x3344` to reg `0x20` → only that write strobes.
- `rst` pulsed during RD_B1 while `sda_oe`=1 → `sda_oe`=0 on the next clk, and the next transaction completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM encoding, bus level constants
// and a small helper that tells which acknowledge slots the target drives.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_REG,
      ST_REG_ACK,
      ST_WR_B1,
      ST_WR_B1_ACK,
      ST_WR_B2,
      ST_WR_B2_ACK,
      ST_RD_B1,
      ST_RD_B1_ACK,
      ST_RD_B2,
      ST_RD_B2_ACK,
      ST_IGNORE
   } state_t;

   localparam logic       I2C_RW_WRITE = 1'b1;
   localparam logic       I2C_ACK      = 1'b0;
   localparam logic       I2C_NACK     = 1'b1;
   localparam logic [3:0] BIT_LAST     = 4'd8;

   // Read-path ack slots belong to the controller, so the target stays off the bus there.
   function automatic logic target_acks(state_t s);
      return (s == ST_ADDR_ACK) || (s == ST_REG_ACK) ||
             (s == ST_WR_B1_ACK) || (s == ST_WR_B2_ACK);
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes SCL/SDA into clk and produces registered one-clk flags for
// SCL edges and START/STOP line conditions, plus the aligned SDA sample.
module i2c_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop,
   output logic sda_smp
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_q;
   logic                   scl_s;
   logic                   sda_s;

   assign scl_s = scl_sync[SYNC_STAGES-1];
   assign sda_s = sda_sync[SYNC_STAGES-1];

   // sda_smp is the SDA level seen on the same edge that raised the flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_q    <= 1'b1;
         sda_smp  <= 1'b1;
         scl_rise <= 1'b0;
         scl_fall <= 1'b0;
         start    <= 1'b0;
         stop     <= 1'b0;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_q    <= scl_s;
         sda_smp  <= sda_s;
         scl_rise <= scl_s & ~scl_q;
         scl_fall <= ~scl_s & scl_q;
         start    <= scl_s & scl_q & sda_smp & ~sda_s;
         stop     <= scl_s & scl_q & ~sda_smp & sda_s;
      end
   end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, register pointer, then a two-byte write or a
// two-byte read through a 16-bit register-file port.
import i2c_pkg::*;

module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDRESS = 7'h42,
   parameter int         SYNC_STAGES   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe,
   output logic [7:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_we,
   output logic        reg_re,
   input  logic [15:0] reg_rdata,
   output logic        busy
);

   logic scl_rise, scl_fall, start, stop, sda_smp;

   i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst      (rst),
      .scl_i    (scl_i),
      .sda_i    (sda_i),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop),
      .sda_smp  (sda_smp)
   );

   state_t      state, state_n;
   logic [3:0]  bit_cnt, cnt_n;
   logic [6:0]  shreg, shreg_n;
   logic [15:0] tx, tx_n;
   logic [7:0]  wr_hi, hi_n;
   logic [7:0]  addr_n;
   logic [15:0] wdata_n;
   logic        rw, rw_n;
   logic        oe_n, we_n, re_n, busy_n;
   logic [7:0]  rx_byte;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bit_cnt   <= 4'd0;
         shreg     <= 7'd0;
         tx        <= 16'd0;
         wr_hi     <= 8'd0;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         reg_addr  <= 8'h00;
         reg_wdata <= 16'h0000;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= cnt_n;
         shreg     <= shreg_n;
         tx        <= tx_n;
         wr_hi     <= hi_n;
         rw        <= rw_n;
         sda_oe    <= oe_n;
         reg_addr  <= addr_n;
         reg_wdata <= wdata_n;
         reg_we    <= we_n;
         reg_re    <= re_n;
         busy      <= busy_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = bit_cnt;
      shreg_n = shreg;
      tx_n    = tx;
      hi_n    = wr_hi;
      rw_n    = rw;
      oe_n    = sda_oe;
      addr_n  = reg_addr;
      wdata_n = reg_wdata;
      we_n    = 1'b0;
      re_n    = 1'b0;
      busy_n  = busy;
      rx_byte = {shreg, sda_smp};

      if (stop) begin
         state_n = ST_IDLE;
         cnt_n   = 4'd0;
         oe_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (start) begin
         state_n = ST_ADDR;
         cnt_n   = 4'd0;
         oe_n    = 1'b0;
         busy_n  = 1'b1;
      end else begin
         // reg_rdata is valid the clk after the request; load it and present bit 15.
         if (reg_re) begin
            tx_n = reg_rdata;
            oe_n = ~reg_rdata[15];
         end
         case (state)
            ST_ADDR, ST_REG, ST_WR_B1, ST_WR_B2: begin
               if (scl_rise) begin
                  shreg_n = rx_byte[6:0];
                  cnt_n   = bit_cnt + 4'd1;
                  if (bit_cnt == BIT_LAST - 4'd1) begin
                     case (state)
                        ST_ADDR: begin
                           rw_n    = rx_byte[0];
                           state_n = (rx_byte[7:1] == SLAVE_ADDRESS) ? ST_ADDR_ACK : ST_IGNORE;
                        end
                        ST_REG: begin
                           addr_n  = rx_byte;
                           state_n = ST_REG_ACK;
                        end
                        ST_WR_B1: begin
                           hi_n    = rx_byte;
                           state_n = ST_WR_B1_ACK;
                        end
                        default: begin
                           wdata_n = {wr_hi, rx_byte};
                           we_n    = 1'b1;
                           state_n = ST_WR_B2_ACK;
                        end
                     endcase
                  end
               end
            end
            ST_RD_B1, ST_RD_B2: begin
               if (scl_rise) begin
                  cnt_n = bit_cnt + 4'd1;
                  if (bit_cnt == BIT_LAST - 4'd1) begin
                     state_n = (state == ST_RD_B1) ? ST_RD_B1_ACK : ST_RD_B2_ACK;
                  end
               end
               if (scl_fall) begin
                  tx_n = {tx[14:0], 1'b0};
                  oe_n = ~tx[14];
               end
            end
            ST_ADDR_ACK, ST_REG_ACK, ST_WR_B1_ACK, ST_WR_B2_ACK,
            ST_RD_B1_ACK, ST_RD_B2_ACK: begin
               // bit_cnt==8 marks the fall opening the 9th period, 0 the fall closing it.
               if (scl_rise) cnt_n = 4'd0;
               if (scl_fall && bit_cnt == BIT_LAST) begin
                  oe_n = target_acks(state) ? ~I2C_ACK : 1'b0;
                  if (state == ST_RD_B1_ACK) tx_n = {tx[14:0], 1'b0};
               end else if (scl_fall && bit_cnt == 4'd0) begin
                  oe_n = 1'b0;
                  case (state)
                     ST_ADDR_ACK:  state_n = ST_REG;
                     ST_REG_ACK: begin
                        if (rw == I2C_RW_WRITE) begin
                           state_n = ST_WR_B1;
                        end else begin
                           state_n = ST_RD_B1;
                           re_n    = 1'b1;
                        end
                     end
                     ST_WR_B1_ACK: state_n = ST_WR_B2;
                     ST_RD_B1_ACK: begin
                        state_n = ST_RD_B2;
                        oe_n    = ~tx[15];
                     end
                     default:      state_n = ST_IGNORE;
                  endcase
               end
            end
            ST_IGNORE: oe_n = 1'b0;
            default:   state_n = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-level I2C controller tasks, a transaction-level
// expectation model, and per-scenario checks.
module tb_i2c_slave;

   localparam int H = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        scl;
   logic        sda_m;
   logic        sda_oe;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic [15:0] reg_rdata;
   logic        reg_we;
   logic        reg_re;
   logic        busy;
   wire         sda_bus = sda_m & ~sda_oe;

   logic [15:0] rd_mem [256];
   logic [23:0] exp_q[$];
   logic [23:0] got_log[$];
   int          got_rd;
   int          re_cnt;
   int          oe_cnt;
   int          checks;
   int          errors;
   logic [15:0] exp_last_wdata;

   assign reg_rdata = rd_mem[reg_addr];

   always #5 clk = ~clk;

   i2c_slave #(.SLAVE_ADDRESS(7'h42), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl),
      .sda_i     (sda_bus),
      .sda_oe    (sda_oe),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   always @(negedge clk) begin
      if (reg_we) got_log.push_back({reg_addr, reg_wdata});
      if (reg_re) re_cnt++;
      if (sda_oe) oe_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, output logic s);
      clks(H/2); sda_m = b;
      clks(H/2); scl = 1'b1;
      clks(H/2); s = sda_bus;
      clks(H/2); scl = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] d, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--) send_bit(d[i], s);
      send_bit(1'b1, s);
      acked = (s == 1'b0);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic m_ack, output logic slot);
      logic s;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         send_bit(1'b1, s);
         d = {d[6:0], s};
      end
      send_bit(m_ack, slot);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; scl = 1'b1;
      clks(H/2); sda_m = 1'b0;
      clks(H);   scl = 1'b0;
   endtask

   task automatic rep_start();
      clks(H/2); sda_m = 1'b1;
      clks(H/2); scl = 1'b1;
      clks(H/2); sda_m = 1'b0;
      clks(H/2); scl = 1'b0;
   endtask

   task automatic bus_stop();
      clks(H/2); sda_m = 1'b0;
      clks(H/2); scl = 1'b1;
      clks(H/2); sda_m = 1'b1;
      clks(H);
   endtask

   // Full transaction; reads use a controller NACK so the bus shows whether the target released SDA.
   task automatic xfer(input logic [6:0] a, input logic rw, input logic [7:0] r,
                       input logic [15:0] wd, output logic [3:0] acks,
                       output logic [15:0] rd, output logic [1:0] slots);
      logic a0, a1, a2, a3, s1, s0;
      logic [7:0] hi, lo;
      a2 = 1'b0; a3 = 1'b0; s1 = 1'b0; s0 = 1'b0; hi = 8'h00; lo = 8'h00;
      bus_start();
      write_byte({a, rw}, a0);
      write_byte(r, a1);
      if (rw) begin
         write_byte(wd[15:8], a2);
         write_byte(wd[7:0], a3);
      end else begin
         read_byte(hi, 1'b1, s1);
         read_byte(lo, 1'b1, s0);
      end
      bus_stop();
      acks  = {a3, a2, a1, a0};
      rd    = {hi, lo};
      slots = {s1, s0};
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
      clks(3);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b want 0", sda_oe); end
      checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got %b want 0", reg_we); end
      checks++; if (reg_re !== 1'b0) begin errors++; $display("FAIL reset_reg_re got %b want 0", reg_re); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_reg_addr got %h want 00", reg_addr); end
      checks++; if (reg_wdata !== 16'h0000) begin errors++; $display("FAIL reset_reg_wdata got %h want 0000", reg_wdata); end
      rst = 1'b0;
      clks(5);
   endtask

   task automatic test_write_basic();
      logic [3:0] acks; logic [15:0] rd; logic [1:0] slots;
      int n0;
      n0 = got_log.size();
      exp_q.push_back({8'h10, 16'hBEEF});
      xfer(7'h42, 1'b1, 8'h10, 16'hBEEF, acks, rd, slots);
      exp_last_wdata = 16'hBEEF;
      checks++; if (acks !== 4'b1111) begin errors++; $display("FAIL write_acks got %b want 1111", acks); end
      checks++; if (got_log.size() !== n0 + 1) begin errors++; $display("FAIL write_we_count got %0d want %0d", got_log.size() - n0, 1); end
      if (got_log.size() > got_rd) begin
         checks++; if (got_log[got_rd] !== exp_q[0]) begin errors++; $display("FAIL write_data got %h want %h", got_log[got_rd], exp_q[0]); end
      end
      got_rd = got_log.size(); exp_q.delete();
      checks++; if (reg_addr !== 8'h10) begin errors++; $display("FAIL write_reg_addr got %h want 10", reg_addr); end
      checks++; if (reg_wdata !== 16'hBEEF) begin errors++; $display("FAIL write_reg_wdata got %h want beef", reg_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop got %b want 0", busy); end
   endtask

   task automatic test_read_basic();
      logic [3:0] acks; logic [15:0] rd; logic [1:0] slots;
      int re0, n0;
      rd_mem[8'h05] = 16'hA55A;
      re0 = re_cnt; n0 = got_log.size();
      xfer(7'h42, 1'b0, 8'h05, 16'h0000, acks, rd, slots);
      checks++; if (acks[1:0] !== 2'b11) begin errors++; $display("FAIL read_acks got %b want 11", acks[1:0]); end
      checks++; if (rd[15:8] !== 8'hA5) begin errors++; $display("FAIL read_byte1 got %h want a5", rd[15:8]); end
      checks++; if (rd[7:0] !== 8'h5A) begin errors++; $display("FAIL read_byte2 got %h want 5a", rd[7:0]); end
      checks++; if (slots !== 2'b11) begin errors++; $display("FAIL read_ack_slots_released got %b want 11", slots); end
      checks++; if (re_cnt - re0 !== 1) begin errors++; $display("FAIL read_re_count got %0d want 1", re_cnt - re0); end
      checks++; if (got_log.size() !== n0) begin errors++; $display("FAIL read_no_we got %0d want 0", got_log.size() - n0); end
   endtask

   task automatic test_addr_mismatch();
      logic a0, a1, a2;
      int re0, n0, oe0;
      re0 = re_cnt; n0 = got_log.size(); oe0 = oe_cnt;
      bus_start();
      clks(4);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mismatch_busy_after_start got %b want 1", busy); end
      write_byte({7'h43, 1'b1}, a0);
      write_byte(8'h10, a1);
      write_byte(8'hAA, a2);
      bus_stop();
      checks++; if ({a2, a1, a0} !== 3'b000) begin errors++; $display("FAIL mismatch_acks got %b want 000", {a2, a1, a0}); end
      checks++; if (oe_cnt !== oe0) begin errors++; $display("FAIL mismatch_sda_oe_cycles got %0d want 0", oe_cnt - oe0); end
      checks++; if (got_log.size() !== n0 || re_cnt !== re0) begin errors++; $display("FAIL mismatch_strobes got we=%0d re=%0d want 0 0", got_log.size() - n0, re_cnt - re0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy_after_stop got %b want 0", busy); end
   endtask

   task automatic test_partial_write();
      logic a0, a1, a2;
      int n0;
      n0 = got_log.size();
      bus_start();
      write_byte({7'h42, 1'b1}, a0);
      write_byte(8'h77, a1);
      write_byte(8'h12, a2);
      bus_stop();
      checks++; if ({a2, a1, a0} !== 3'b111) begin errors++; $display("FAIL partial_acks got %b want 111", {a2, a1, a0}); end
      checks++; if (got_log.size() !== n0) begin errors++; $display("FAIL partial_no_we got %0d want 0", got_log.size() - n0); end
      checks++; if (reg_wdata !== exp_last_wdata) begin errors++; $display("FAIL partial_wdata_held got %h want %h", reg_wdata, exp_last_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_repeated_start();
      logic a0, a1, a2, a3, a4, s;
      int n0;
      n0 = got_log.size();
      bus_start();
      write_byte({7'h42, 1'b1}, a0);
      for (int i = 0; i < 4; i++) send_bit(i[0], s);
      rep_start();
      write_byte({7'h42, 1'b1}, a1);
      write_byte(8'h20, a2);
      write_byte(8'h33, a3);
      write_byte(8'h44, a4);
      bus_stop();
      exp_last_wdata = 16'h3344;
      checks++; if ({a4, a3, a2, a1, a0} !== 5'b11111) begin errors++; $display("FAIL rstart_acks got %b want 11111", {a4, a3, a2, a1, a0}); end
      checks++; if (got_log.size() !== n0 + 1) begin errors++; $display("FAIL rstart_we_count got %0d want 1", got_log.size() - n0); end
      if (got_log.size() > got_rd) begin
         checks++; if (got_log[got_rd] !== {8'h20, 16'h3344}) begin errors++; $display("FAIL rstart_write got %h want 203344", got_log[got_rd]); end
      end
      got_rd = got_log.size();
   endtask

   task automatic test_reset_mid_read();
      logic a0, a1;
      logic [3:0] acks; logic [15:0] rd; logic [1:0] slots;
      logic [15:0] d;
      rd_mem[8'h31] = 16'h1234;
      bus_start();
      write_byte({7'h42, 1'b0}, a0);
      write_byte(8'h31, a1);
      clks(8);
      checks++; if (sda_oe !== 1'b1) begin errors++; $display("FAIL midread_driving got %b want 1", sda_oe); end
      rst = 1'b1;
      clks(1);
      checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL midread_reset_release got %b want 0", sda_oe); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midread_reset_busy got %b want 0", busy); end
      rst = 1'b0;
      exp_last_wdata = 16'h0000;
      got_rd = got_log.size();
      clks(4);
      bus_stop();
      d = 16'($urandom);
      xfer(7'h42, 1'b1, 8'h66, d, acks, rd, slots);
      exp_last_wdata = d;
      checks++; if (acks !== 4'b1111) begin errors++; $display("FAIL midread_next_acks got %b want 1111", acks); end
      checks++; if (got_log.size() !== got_rd + 1 || got_log[got_log.size() - 1] !== {8'h66, d}) begin
         errors++; $display("FAIL midread_next_write got n=%0d want %h", got_log.size() - got_rd, {8'h66, d});
      end
      got_rd = got_log.size();
   endtask

   task automatic test_random();
      logic [3:0] acks; logic [15:0] rd; logic [1:0] slots;
      logic [6:0] a; logic rw; logic [7:0] r; logic [15:0] d;
      logic [3:0] exp_acks; logic [15:0] exp_rd;
      int re0, n0;
      for (int t = 0; t < 12; t++) begin
         a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h42;
         rw = 1'($urandom_range(0, 1));
         r  = 8'($urandom);
         d  = 16'($urandom);
         exp_rd = rd_mem[r];
         re0 = re_cnt; n0 = got_log.size();
         if (a == 7'h42) begin
            exp_acks = rw ? 4'b1111 : 4'b0011;
            if (rw) begin
               exp_q.push_back({r, d});
               exp_last_wdata = d;
            end
         end else begin
            exp_acks = 4'b0000;
         end
         xfer(a, rw, r, d, acks, rd, slots);
         checks++; if (acks !== exp_acks) begin errors++; $display("FAIL rand%0d_acks got %b want %b", t, acks, exp_acks); end
         checks++; if (got_log.size() - n0 !== exp_q.size()) begin errors++; $display("FAIL rand%0d_we_count got %0d want %0d", t, got_log.size() - n0, exp_q.size()); end
         while (exp_q.size() > 0 && got_rd < got_log.size()) begin
            checks++; if (got_log[got_rd] !== exp_q[0]) begin errors++; $display("FAIL rand%0d_write got %h want %h", t, got_log[got_rd], exp_q[0]); end
            void'(exp_q.pop_front());
            got_rd++;
         end
         exp_q.delete(); got_rd = got_log.size();
         if (a == 7'h42 && !rw) begin
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand%0d_read got %h want %h", t, rd, exp_rd); end
            checks++; if (re_cnt - re0 !== 1) begin errors++; $display("FAIL rand%0d_re_count got %0d want 1", t, re_cnt - re0); end
         end else begin
            checks++; if (re_cnt !== re0) begin errors++; $display("FAIL rand%0d_no_re got %0d want 0", t, re_cnt - re0); end
         end
         checks++; if (reg_wdata !== exp_last_wdata) begin errors++; $display("FAIL rand%0d_wdata got %h want %h", t, reg_wdata, exp_last_wdata); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy got %b want 0", t, busy); end
      end
   endtask

   initial begin
      #3ms;
      errors++;
      $display("FAIL watchdog expired before end of sequence");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; errors = 0; got_rd = 0; re_cnt = 0; oe_cnt = 0;
      exp_last_wdata = 16'h0000;
      rst = 1'b1; scl = 1'b1; sda_m = 1'b1;
      for (int i = 0; i < 256; i++) rd_mem[i] = 16'($urandom);
      test_reset();
      test_write_basic();
      test_read_basic();
      test_addr_mismatch();
      test_partial_write();
      test_repeated_start();
      test_reset_mid_read();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
